// File: rtl/ysyx_22050710_npc_mc.sv
// Multi-cycle RV64I/RV32I NPC core with valid/ready imem and dmem handshakes.
// Optional commit trace outputs are enabled by defining NPC_COMMIT_TRACE_EN.
module ysyx_22050710_npc_mc #(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_imem_req_valid,
    input  logic                i_imem_req_ready,
    output logic [XLEN-1:0]     o_imem_addr,
    input  logic                i_imem_rsp_valid,
    input  logic [31:0]         i_imem_rdata,
    output logic                o_dmem_req_valid,
    input  logic                i_dmem_req_ready,
    output logic                o_dmem_wen,
    output logic [XLEN-1:0]     o_dmem_addr,
    output logic [XLEN-1:0]     o_dmem_wdata,
    output logic [XLEN/8-1:0]   o_dmem_wmask,
    input  logic                i_dmem_rsp_valid,
    input  logic [XLEN-1:0]     i_dmem_rdata,
`ifdef NPC_COMMIT_TRACE_EN
    output logic                o_commit_valid,
    output logic [XLEN-1:0]     o_commit_pc,
    output logic [31:0]         o_commit_inst,
    output logic [4:0]          o_commit_rd,
    output logic [XLEN-1:0]     o_commit_wdata,
`endif
    output logic [XLEN-1:0]     o_pc,
    output logic                o_halt,
    output logic [1:0]          o_halt_code
);
    // state   | meaning
    // FETCH   | imem request outstanding until ready
    // WAIT_I  | waiting for instruction word
    // EXEC    | decode/execute latched instruction
    // MEM_REQ | dmem request held until ready
    // WAIT_D  | waiting for load data / store ack
    // HALT    | ebreak or trap, absorbing until reset
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_WAIT_I  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_MEM_REQ = 3'd3;
    localparam logic [2:0] S_WAIT_D  = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    logic [2:0]      state;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [1:0]      halt_code;
    logic [XLEN-1:0] gpr [32];

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1_idx, rs2_idx;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = inst[6:0];
    assign rd      = inst[11:7];
    assign funct3  = inst[14:12];
    assign rs1_idx = inst[19:15];
    assign rs2_idx = inst[24:20];
    assign rs1     = (rs1_idx == 5'd0) ? '0 : gpr[rs1_idx];
    assign rs2     = (rs2_idx == 5'd0) ? '0 : gpr[rs2_idx];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    logic is_load, is_store, is_mem, is_ebreak, is_reg_op;
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_mem    = is_load | is_store;
    assign is_ebreak = (inst == 32'h0010_0073);
    assign is_reg_op = (opcode == OP_OP) | (opcode == OP_OP32);

    // exu: full-width and 32-bit (W) results computed side by side
    logic [XLEN-1:0] alu_b, alu_res;
    logic [5:0]      shamt;
    logic [31:0]     w_res;
    logic            sub;

    always_comb begin
        alu_b   = is_reg_op ? rs2 : imm_i;
        shamt   = (XLEN == 64) ? alu_b[5:0] : {1'b0, alu_b[4:0]};
        sub     = is_reg_op & inst[30];
        alu_res = '0;
        w_res   = '0;
        case (funct3)
            3'b000:  alu_res = sub ? rs1 - alu_b : rs1 + alu_b;
            3'b001:  alu_res = rs1 << shamt;
            3'b010:  alu_res = XLEN'($signed(rs1) < $signed(alu_b));
            3'b011:  alu_res = XLEN'(rs1 < alu_b);
            3'b100:  alu_res = rs1 ^ alu_b;
            3'b101:  alu_res = inst[30] ? XLEN'($signed(rs1) >>> shamt) : rs1 >> shamt;
            3'b110:  alu_res = rs1 | alu_b;
            default: alu_res = rs1 & alu_b;
        endcase
        case (funct3)
            3'b000:  w_res = sub ? rs1[31:0] - alu_b[31:0] : rs1[31:0] + alu_b[31:0];
            3'b001:  w_res = rs1[31:0] << shamt[4:0];
            3'b101:  w_res = inst[30] ? 32'($signed(rs1[31:0]) >>> shamt[4:0])
                                      : rs1[31:0] >> shamt[4:0];
            default: w_res = '0;
        endcase
    end

    logic br_taken;
    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1 == rs2);
            3'b001:  br_taken = (rs1 != rs2);
            3'b100:  br_taken = ($signed(rs1) < $signed(rs2));
            3'b101:  br_taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  br_taken = (rs1 < rs2);
            3'b111:  br_taken = (rs1 >= rs2);
            default: br_taken = 1'b0;
        endcase
    end

    // Memory address, lane placement and trap detection
    logic [XLEN-1:0] eff_addr, ld_shift, ld_data;
    logic [OFFW-1:0] off;
    logic [NB-1:0]   size_mask;
    logic            misaligned, mem_illegal, mem_trap;

    assign eff_addr = rs1 + (is_store ? imm_s : imm_i);
    assign off      = eff_addr[OFFW-1:0];
    assign ld_shift = i_dmem_rdata >> {off, 3'b000};

    always_comb begin
        case (funct3[1:0])
            2'd0:    begin misaligned = 1'b0;            size_mask = NB'(8'h01); end
            2'd1:    begin misaligned = eff_addr[0];     size_mask = NB'(8'h03); end
            2'd2:    begin misaligned = |eff_addr[1:0];  size_mask = NB'(8'h0F); end
            default: begin misaligned = |eff_addr[2:0];  size_mask = NB'(8'hFF); end
        endcase
        if (is_load)
            mem_illegal = (funct3 == 3'b111) ||
                          ((XLEN == 32) && (funct3 == 3'b011 || funct3 == 3'b110));
        else if (is_store)
            mem_illegal = funct3[2] || ((XLEN == 32) && (funct3[1:0] == 2'b11));
        else
            mem_illegal = 1'b0;
        mem_trap = is_mem & (misaligned | mem_illegal);
        case (funct3)
            3'b000:  ld_data = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_data = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_data = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_data = XLEN'(ld_shift[7:0]);
            3'b101:  ld_data = XLEN'(ld_shift[15:0]);
            3'b110:  ld_data = XLEN'(ld_shift[31:0]);
            default: ld_data = ld_shift;
        endcase
    end

    // idu: write-back select and next-PC operand select
    logic            wb_en, pc_a_src, pc_b_src;
    logic [XLEN-1:0] wb_data, next_pc;

    always_comb begin
        wb_en    = 1'b0;
        wb_data  = alu_res;
        pc_a_src = 1'b0;
        pc_b_src = 1'b0;
        case (opcode)
            OP_LUI:    begin wb_en = 1'b1; wb_data = imm_u; end
            OP_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u; end
            OP_JAL:    begin wb_en = 1'b1; wb_data = pc + XLEN'(4); pc_a_src = 1'b1; end
            OP_JALR:   begin
                wb_en    = 1'b1;
                wb_data  = pc + XLEN'(4);
                pc_a_src = 1'b1;
                pc_b_src = 1'b1;
            end
            OP_BRANCH: pc_a_src = br_taken;
            OP_LOAD:   begin wb_en = 1'b1; wb_data = ld_data; end
            OP_IMM, OP_OP: wb_en = 1'b1;
            OP_IMM32, OP_OP32: begin
                wb_en   = (XLEN == 64);
                wb_data = XLEN'($signed(w_res));
            end
            default: ;
        endcase
        next_pc = (pc_b_src ? rs1 : pc) +
                  (pc_a_src ? ((opcode == OP_JAL) ? imm_j :
                               (opcode == OP_JALR) ? imm_i : imm_b) : XLEN'(4));
        if (opcode == OP_JALR)
            next_pc[0] = 1'b0;
    end

    logic commit;
    assign commit = ~i_rst &
                    (((state == S_EXEC) & ~is_ebreak & ~is_mem) |
                     ((state == S_WAIT_D) & i_dmem_rsp_valid));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            inst      <= '0;
            halt_code <= 2'd0;
        end else begin
            case (state)
                S_FETCH:  if (i_imem_req_ready) state <= S_WAIT_I;
                S_WAIT_I: if (i_imem_rsp_valid) begin
                    inst  <= i_imem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_ebreak) begin
                        state     <= S_HALT;
                        halt_code <= 2'd1;
                    end else if (mem_trap) begin
                        state     <= S_HALT;
                        halt_code <= 2'd2;
                    end else if (is_mem) begin
                        state <= S_MEM_REQ;
                    end else begin
                        pc    <= next_pc;
                        state <= S_FETCH;
                    end
                end
                S_MEM_REQ: if (i_dmem_req_ready) state <= S_WAIT_D;
                S_WAIT_D:  if (i_dmem_rsp_valid) begin
                    pc    <= next_pc;
                    state <= S_FETCH;
                end
                S_HALT:  ;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (commit && wb_en && rd != 5'd0)
            gpr[rd] <= wb_data;
    end

`ifdef NPC_COMMIT_TRACE_EN
    logic trace_evt;
    assign trace_evt = commit | (~i_rst & (state == S_EXEC) & is_ebreak);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_commit_valid <= 1'b0;
            o_commit_pc    <= '0;
            o_commit_inst  <= '0;
            o_commit_rd    <= '0;
            o_commit_wdata <= '0;
        end else begin
            o_commit_valid <= trace_evt;
            if (trace_evt) begin
                o_commit_pc    <= pc;
                o_commit_inst  <= inst;
                o_commit_rd    <= (commit && wb_en) ? rd : 5'd0;
                o_commit_wdata <= (commit && wb_en && rd != 5'd0) ? wb_data : '0;
            end
        end
    end
`endif

    assign o_imem_req_valid = (state == S_FETCH);
    assign o_imem_addr      = pc;
    assign o_dmem_req_valid = (state == S_MEM_REQ);
    assign o_dmem_wen       = (state == S_MEM_REQ) & is_store;
    assign o_dmem_addr      = eff_addr & ~XLEN'(NB - 1);
    assign o_dmem_wdata     = rs2 << {off, 3'b000};
    assign o_dmem_wmask     = ((state == S_MEM_REQ) & is_store) ? (size_mask << off) : '0;
    assign o_pc             = pc;
    assign o_halt           = (state == S_HALT);
    assign o_halt_code      = halt_code;
endmodule

// File: tb/tb_ysyx_22050710_npc_mc.sv
// Directed bench for ysyx_22050710_npc_mc (XLEN=64) with small imem/dmem responders.
module tb_ysyx_22050710_npc_mc;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h13;
    logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_wen;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_rsp_valid = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic [63:0] pc;
    logic        halt;
    logic [1:0]  halt_code;

    ysyx_22050710_npc_mc dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req_valid(imem_req_valid), .i_imem_req_ready(imem_req_ready),
        .o_imem_addr(imem_addr), .i_imem_rsp_valid(imem_rsp_valid), .i_imem_rdata(imem_rdata),
        .o_dmem_req_valid(dmem_req_valid), .i_dmem_req_ready(dmem_req_ready),
        .o_dmem_wen(dmem_wen), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .o_dmem_wmask(dmem_wmask), .i_dmem_rsp_valid(dmem_rsp_valid), .i_dmem_rdata(dmem_rdata),
        .o_pc(pc), .o_halt(halt), .o_halt_code(halt_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    logic [31:0] prog [32];
    logic [63:0] dm [8];
    logic        i_pend = 1'b0, d_pend = 1'b0;
    logic [31:0] i_word = 32'h13;
    logic [63:0] d_word = '0;
    int          d_cnt = 0, d_delay = 0;
    logic        d_hold = 1'b0, force_drsp = 1'b0;
    int          st_cnt = 0, d_valid_cnt = 0;
    logic [63:0] st_addr, st_wdata, st_pc;
    logic [7:0]  st_wmask;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive responder inputs at negedge, update responder state after posedge.
    task automatic tick();
        logic ia, da, dv;
        logic [63:0] ioff;
        @(negedge clk);
        imem_req_ready = 1'b1;
        imem_rsp_valid = i_pend;
        imem_rdata     = i_word;
        dmem_req_ready = dmem_req_valid && (d_cnt >= d_delay);
        dmem_rsp_valid = (d_pend && !d_hold) || force_drsp;
        dmem_rdata     = d_pend ? d_word : 64'hDEAD_BEEF_DEAD_BEEF;
        ia = imem_req_valid && imem_req_ready;
        dv = dmem_req_valid;
        da = dmem_req_valid && dmem_req_ready;
        if (dv) d_valid_cnt++;
        if (da && !rst) begin
            d_word = dm[dmem_addr[5:3]];
            if (dmem_wen) begin
                for (int b = 0; b < 8; b++)
                    if (dmem_wmask[b]) dm[dmem_addr[5:3]][8*b +: 8] = dmem_wdata[8*b +: 8];
                st_addr = dmem_addr; st_wdata = dmem_wdata; st_wmask = dmem_wmask; st_pc = pc;
                st_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            i_pend = 1'b0; d_pend = 1'b0; d_cnt = 0;
        end else begin
            if (imem_rsp_valid) i_pend = 1'b0;
            if (ia) begin
                ioff   = (imem_addr - RESET_PC) >> 2;
                i_word = (ioff < 64'd32) ? prog[ioff[4:0]] : 32'h13;
                i_pend = 1'b1;
            end
            if (dmem_rsp_valid) d_pend = 1'b0;
            if (da) begin d_pend = 1'b1; d_cnt = 0; end
            else if (dv) d_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_until_store(input string tag, input int limit);
        int start;
        logic seen;
        start = st_cnt;
        seen  = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (st_cnt != start) seen = 1'b1;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic run_until_halt(input string tag, input int limit);
        for (int i = 0; i < limit && !halt; i++) tick();
        check({tag, "_halt"}, 64'(halt), 64'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) prog[i] = 32'h13;
        for (int i = 0; i < 8; i++) dm[i] = '0;
    endtask

    int vcnt;

    initial begin
        // Phase A: addi, sd/ld round-trip with slow dmem, x0 discard
        clear_mem();
        prog[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = enc_s(12'd8, 5'd1, 5'd0, 3'b011);
        prog[2] = enc_i(12'd8, 5'd0, 3'b011, 5'd2, 7'b0000011);
        prog[3] = enc_s(12'd16, 5'd2, 5'd0, 3'b011);
        prog[4] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
        prog[5] = enc_s(12'd24, 5'd0, 5'd0, 3'b011);
        d_delay = 2;
        do_reset();
        check("rst_pc", pc, RESET_PC);
        check("rst_halt", {63'd0, halt}, 64'd0);
        check("rst_code", {62'd0, halt_code}, 64'd0);
        check("rst_ireq", {63'd0, imem_req_valid}, 64'd1);
        check("rst_dreq", {63'd0, dmem_req_valid}, 64'd0);
        check("rst_wen", {63'd0, dmem_wen}, 64'd0);
        check("rst_wmask", {56'd0, dmem_wmask}, 64'd0);
        tick(); tick();
        check("addi_edge2_pc", pc, RESET_PC);
        tick();
        check("addi_edge3_pc", pc, RESET_PC + 64'd4);
        for (int i = 0; i < 6; i++) tick();
        check("sd_edge6_pc", pc, RESET_PC + 64'd4);
        tick();
        check("sd_edge7_pc", pc, RESET_PC + 64'd8);
        check("sd_cnt", 64'(st_cnt), 64'd1);
        check("sd_addr", st_addr, 64'd8);
        check("sd_wmask", {56'd0, st_wmask}, 64'hFF);
        check("sd_wdata", st_wdata, 64'd5);
        for (int i = 0; i < 6; i++) tick();
        check("ld_edge6_pc", pc, RESET_PC + 64'd8);
        tick();
        check("ld_edge7_pc", pc, RESET_PC + 64'd12);
        run_until_store("sd_x2", 30);
        check("sd_x2_addr", st_addr, 64'd16);
        check("sd_x2_wdata", st_wdata, 64'd5);
        run_until_store("sd_x0", 40);
        check("sd_x0_wdata", st_wdata, 64'd0);

        // Phase B: byte store lane placement, lb/lbu/lh extension
        clear_mem();
        dm[3] = 64'h0000_0000_0080_0000;
        prog[0] = enc_u(20'h00001, 5'd4, 7'b0110111);
        prog[1] = enc_i(12'h234, 5'd4, 3'b000, 5'd4, 7'b0010011);
        prog[2] = enc_s(12'h013, 5'd4, 5'd0, 3'b000);
        prog[3] = enc_i(12'h01A, 5'd0, 3'b000, 5'd5, 7'b0000011);
        prog[4] = enc_s(12'h020, 5'd5, 5'd0, 3'b011);
        prog[5] = enc_i(12'h01A, 5'd0, 3'b100, 5'd6, 7'b0000011);
        prog[6] = enc_s(12'h028, 5'd6, 5'd0, 3'b011);
        prog[7] = enc_i(12'h012, 5'd0, 3'b001, 5'd7, 7'b0000011);
        prog[8] = enc_s(12'h030, 5'd7, 5'd0, 3'b011);
        d_delay = 0;
        do_reset();
        run_until_store("sb", 40);
        check("sb_addr", st_addr, 64'h10);
        check("sb_wmask", {56'd0, st_wmask}, 64'h08);
        check("sb_wdata", st_wdata, 64'h0000_0012_3400_0000);
        run_until_store("sd_lb", 40);
        check("lb_sext", st_wdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_until_store("sd_lbu", 40);
        check("lbu_zext", st_wdata, 64'h80);
        run_until_store("sd_lh", 40);
        check("lh_after_sb", st_wdata, 64'h3400);

        // Phase C: jalr bit0 clear and link, then misaligned lw trap
        clear_mem();
        prog[0] = enc_u(20'h00000, 5'd5, 7'b0010111);
        prog[1] = enc_i(12'h011, 5'd5, 3'b000, 5'd5, 7'b0010011);
        prog[2] = enc_i(12'h000, 5'd5, 3'b000, 5'd1, 7'b1100111);
        prog[3] = enc_i(12'h000, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[4] = enc_s(12'h000, 5'd1, 5'd0, 3'b011);
        prog[5] = enc_i(12'h002, 5'd0, 3'b010, 5'd7, 7'b0000011);
        do_reset();
        run_until_store("sd_link", 40);
        check("jalr_pc", st_pc, 64'h8000_0010);
        check("jalr_link", st_wdata, 64'h8000_000C);
        tick();
        vcnt = d_valid_cnt;
        run_until_halt("lw_mis", 40);
        check("lw_mis_code", {62'd0, halt_code}, 64'd2);
        check("lw_mis_pc", pc, 64'h8000_0014);
        check("lw_mis_noreq", 64'(d_valid_cnt - vcnt), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        check("halt_sticky", {63'd0, halt}, 64'd1);
        check("halt_no_ireq", {63'd0, imem_req_valid}, 64'd0);

        // Phase D: ebreak
        clear_mem();
        prog[0] = 32'h0010_0073;
        do_reset();
        check("ebreak_rst_halt", {63'd0, halt}, 64'd0);
        tick(); tick(); tick();
        check("ebreak_halt", {63'd0, halt}, 64'd1);
        check("ebreak_code", {62'd0, halt_code}, 64'd1);
        check("ebreak_pc", pc, RESET_PC);

        // Phase E: reset in WAIT_D, stale dmem response afterwards
        clear_mem();
        dm[0] = 64'h1122_3344_5566_7788;
        prog[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd1, 7'b0010011);
        prog[1] = enc_i(12'd0, 5'd0, 3'b011, 5'd2, 7'b0000011);
        prog[2] = enc_s(12'h030, 5'd2, 5'd0, 3'b011);
        prog[3] = enc_s(12'h038, 5'd1, 5'd0, 3'b011);
        d_hold = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        check("waitd_dreq", {63'd0, dmem_req_valid}, 64'd0);
        check("waitd_pc", pc, RESET_PC + 64'd4);
        do_reset();
        d_hold = 1'b0;
        force_drsp = 1'b1;
        check("rerst_ireq", {63'd0, imem_req_valid}, 64'd1);
        check("rerst_iaddr", imem_addr, RESET_PC);
        tick(); tick(); tick();
        force_drsp = 1'b0;
        check("rerst_addi_pc", pc, RESET_PC + 64'd4);
        run_until_store("rerst_sd_x2", 40);
        check("rerst_ld_data", st_wdata, 64'h1122_3344_5566_7788);
        run_until_store("rerst_sd_x1", 40);
        check("rerst_x1", st_wdata, 64'd9);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
